spu_issue: RTL

SPU_ISSUE -- requirements
Module: spu_issue

---
 rtl/spu_issue.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/spu_issue.sv
// spu_issue: dual-issue stage for a decoded instruction pair.
// A two-entry in-order buffer (s0 older, s1 younger) feeds two register-file
// ports. A per-register countdown scoreboard tracks results still in flight,
// and the issue decision is made combinationally from the buffer and the
// scoreboard, then registered onto the iss_* outputs.
module spu_issue #(
    parameter int REGBITS = 7,
    parameter int LATBITS = 3
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               in_valid,
    output logic               in_ready,

    input  logic               in_pipe_0,
    input  logic               in_pipe_1,
    input  logic [REGBITS-1:0] in_ra_0,
    input  logic [REGBITS-1:0] in_ra_1,
    input  logic [REGBITS-1:0] in_rb_0,
    input  logic [REGBITS-1:0] in_rb_1,
    input  logic [REGBITS-1:0] in_rt_0,
    input  logic [REGBITS-1:0] in_rt_1,
    input  logic               in_use_ra_0,
    input  logic               in_use_ra_1,
    input  logic               in_use_rb_0,
    input  logic               in_use_rb_1,
    input  logic               in_wr_0,
    input  logic               in_wr_1,
    input  logic [LATBITS-1:0] in_lat_0,
    input  logic [LATBITS-1:0] in_lat_1,

    output logic               iss_valid_0,
    output logic               iss_valid_1,
    output logic               iss_pipe_0,
    output logic               iss_pipe_1,
    output logic [REGBITS-1:0] iss_ra_0,
    output logic [REGBITS-1:0] iss_ra_1,
    output logic [REGBITS-1:0] iss_rb_0,
    output logic [REGBITS-1:0] iss_rb_1,
    output logic [REGBITS-1:0] iss_rt_0,
    output logic [REGBITS-1:0] iss_rt_1
);

    localparam int NREG = 1 << REGBITS;
    localparam logic [LATBITS-1:0] LAT_ZERO = {LATBITS{1'b0}};
    localparam logic [LATBITS-1:0] LAT_ONE  = {{(LATBITS-1){1'b0}}, 1'b1};
    localparam logic [REGBITS-1:0] REG_ZERO = {REGBITS{1'b0}};

    // One buffered instruction (validity kept separately per slot).
    typedef struct packed {
        logic               pipe;
        logic [REGBITS-1:0] ra;
        logic [REGBITS-1:0] rb;
        logic [REGBITS-1:0] rt;
        logic               use_ra;
        logic               use_rb;
        logic               wr;
        logic [LATBITS-1:0] lat;
    } instr_t;

    // ------------------------------------------------------------------
    // Hazard helpers
    // ------------------------------------------------------------------

    // True when an instruction may not issue because of scoreboard state:
    // a used source still in flight, or its target still owned by an
    // older in-flight write.
    function automatic logic f_sb_blocked(
        input instr_t ins,
        input logic   busy_ra,
        input logic   busy_rb,
        input logic   busy_rt
    );
        return (ins.use_ra & busy_ra) | (ins.use_rb & busy_rb) | (ins.wr & busy_rt);
    endfunction

    // True when the younger instruction depends on the older one of the
    // same pair: reads the older's target (RAW) or writes the same target
    // (WAW). Either way it has to wait for a later cycle.
    function automatic logic f_pair_conflict(
        input instr_t older,
        input instr_t younger
    );
        logic raw_a;
        logic raw_b;
        logic waw;
        raw_a = older.wr & younger.use_ra & (younger.ra == older.rt);
        raw_b = older.wr & younger.use_rb & (younger.rb == older.rt);
        waw   = older.wr & younger.wr & (younger.rt == older.rt);
        return raw_a | raw_b | waw;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    instr_t             r_s0;
    instr_t             r_s1;
    logic               r_v0;
    logic               r_v1;
    logic [LATBITS-1:0] r_count [NREG];

    instr_t w_in0;
    instr_t w_in1;
    logic   w_busy_ra0;
    logic   w_busy_rb0;
    logic   w_busy_rt0;
    logic   w_busy_ra1;
    logic   w_busy_rb1;
    logic   w_busy_rt1;
    logic   w_iss0;
    logic   w_iss1;
    logic   w_ready;

    assign w_in0 = {in_pipe_0, in_ra_0, in_rb_0, in_rt_0,
                    in_use_ra_0, in_use_rb_0, in_wr_0, in_lat_0};
    assign w_in1 = {in_pipe_1, in_ra_1, in_rb_1, in_rt_1,
                    in_use_ra_1, in_use_rb_1, in_wr_1, in_lat_1};

    assign w_busy_ra0 = (r_count[r_s0.ra] != LAT_ZERO);
    assign w_busy_rb0 = (r_count[r_s0.rb] != LAT_ZERO);
    assign w_busy_rt0 = (r_count[r_s0.rt] != LAT_ZERO);
    assign w_busy_ra1 = (r_count[r_s1.ra] != LAT_ZERO);
    assign w_busy_rb1 = (r_count[r_s1.rb] != LAT_ZERO);
    assign w_busy_rt1 = (r_count[r_s1.rt] != LAT_ZERO);

    // Issue decision and pair acceptance, purely from buffer and scoreboard.
    always_comb begin
        w_iss0  = 1'b0;
        w_iss1  = 1'b0;
        w_ready = 1'b0;

        w_iss0 = r_v0 & ~f_sb_blocked(r_s0, w_busy_ra0, w_busy_rb0, w_busy_rt0);

        // The younger slot only rides along with the older one, and only
        // onto the other pipe.
        w_iss1 = w_iss0 & r_v1
               & (r_s1.pipe != r_s0.pipe)
               & ~f_sb_blocked(r_s1, w_busy_ra1, w_busy_rb1, w_busy_rt1)
               & ~f_pair_conflict(r_s0, r_s1);

        // A new pair fits only if the buffer drains completely this cycle.
        if (reset) begin
            w_ready = 1'b0;
        end else if (!r_v0) begin
            w_ready = 1'b1;
        end else if (w_iss0 && (!r_v1 || w_iss1)) begin
            w_ready = 1'b1;
        end else begin
            w_ready = 1'b0;
        end
    end

    assign in_ready = w_ready;

    // Scoreboard: count down every in-flight result; a fresh issue overrides.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_count[i] <= LAT_ZERO;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (r_count[i] != LAT_ZERO) begin
                    r_count[i] <= r_count[i] - LAT_ONE;
                end else begin
                    r_count[i] <= r_count[i];
                end
            end
            // Both slots writing the same target never issue together, so
            // these two updates cannot collide.
            if (w_iss0 && r_s0.wr && (r_s0.lat != LAT_ZERO)) begin
                r_count[r_s0.rt] <= r_s0.lat;
            end
            if (w_iss1 && r_s1.wr && (r_s1.lat != LAT_ZERO)) begin
                r_count[r_s1.rt] <= r_s1.lat;
            end
        end
    end

    // Buffer: load a new pair, shift a held younger slot forward, or retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_s0 <= '0;
            r_s1 <= '0;
        end else if (in_valid && w_ready) begin
            r_s0 <= w_in0;
            r_s1 <= w_in1;
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else if (w_iss0 && !w_iss1) begin
            // Older slot left alone; the younger one becomes the head.
            r_s0 <= r_s1;
            r_v0 <= r_v1;
            r_v1 <= 1'b0;
        end else if (w_iss1) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
        end else begin
            r_v0 <= r_v0;
            r_v1 <= r_v1;
        end
    end

    // Issue registers: valid follows the decision, fields hold between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid_0 <= 1'b0;
            iss_valid_1 <= 1'b0;
            iss_pipe_0  <= 1'b0;
            iss_pipe_1  <= 1'b0;
            iss_ra_0    <= REG_ZERO;
            iss_ra_1    <= REG_ZERO;
            iss_rb_0    <= REG_ZERO;
            iss_rb_1    <= REG_ZERO;
            iss_rt_0    <= REG_ZERO;
            iss_rt_1    <= REG_ZERO;
        end else begin
            iss_valid_0 <= w_iss0;
            iss_valid_1 <= w_iss1;
            if (w_iss0) begin
                iss_pipe_0 <= r_s0.pipe;
                iss_ra_0   <= r_s0.ra;
                iss_rb_0   <= r_s0.rb;
                iss_rt_0   <= r_s0.rt;
            end
            if (w_iss1) begin
                iss_pipe_1 <= r_s1.pipe;
                iss_ra_1   <= r_s1.ra;
                iss_rb_1   <= r_s1.rb;
                iss_rt_1   <= r_s1.rt;
            end
        end
    end

endmodule
